// File: rtl/regfile_dual_pkg.sv
// Shared writeback-bus layout for the dual-write register file.
// Bus = {we, waddr, wdata}; field offsets are used by the RF and its producers.
package regfile_dual_pkg;

  localparam int WS_TO_RF_BUS_WD = 41;

  localparam int RF_WE_MSB    = 40;
  localparam int RF_WE_LSB    = 37;
  localparam int RF_WADDR_MSB = 36;
  localparam int RF_WADDR_LSB = 32;
  localparam int RF_WDATA_MSB = 31;
  localparam int RF_WDATA_LSB = 0;

  localparam int RF_AW = RF_WADDR_MSB - RF_WADDR_LSB + 1;

endpackage

// File: rtl/regfile_dual_byte_merge.sv
// rf_byte_merge: per-byte resolution of two writers against one target register.
// Where both writers hit the same lane, the younger one (main if ws_first_sub) wins.
module rf_byte_merge
  import regfile_dual_pkg::*;
#(
  parameter int NB = 4,
  parameter int AW = RF_AW,
  parameter int DW = 32
) (
  input  logic [NB-1:0] we_main,
  input  logic [AW-1:0] waddr_main,
  input  logic [DW-1:0] wdata_main,
  input  logic [NB-1:0] we_sub,
  input  logic [AW-1:0] waddr_sub,
  input  logic [DW-1:0] wdata_sub,
  input  logic          ws_first_sub,
  input  logic [AW-1:0] tgt,
  output logic [NB-1:0] be,
  output logic [DW-1:0] bdata
);

  logic [NB-1:0] w_hit_m;
  logic [NB-1:0] w_hit_s;

  assign w_hit_m = (waddr_main == tgt) ? we_main : '0;
  assign w_hit_s = (waddr_sub  == tgt) ? we_sub  : '0;
  assign be      = w_hit_m | w_hit_s;

  always_comb begin
    bdata = '0;
    for (int b = 0; b < NB; b++) begin
      if (w_hit_m[b] && (!w_hit_s[b] || ws_first_sub))
        bdata[b*8 +: 8] = wdata_main[b*8 +: 8];
      else if (w_hit_s[b])
        bdata[b*8 +: 8] = wdata_sub[b*8 +: 8];
    end
  end

endmodule

// File: rtl/regfile_dual.sv
// Dual-write, quad-read register file with byte-masked writes and program-order priority.
// Optional macro RF_BYPASS_EN forwards same-cycle merged write bytes to the read ports.
module regfile_dual
  import regfile_dual_pkg::*;
#(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus_main,
  input  logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus_sub,
  input  logic                       ws_first_sub,
  input  logic [RF_AW-1:0]           raddr0,
  input  logic [RF_AW-1:0]           raddr1,
  input  logic [RF_AW-1:0]           raddr2,
  input  logic [RF_AW-1:0]           raddr3,
  output logic [DW-1:0]              rdata0,
  output logic [DW-1:0]              rdata1,
  output logic [DW-1:0]              rdata2,
  output logic [DW-1:0]              rdata3,
  output logic                       wr_conflict
);

  localparam int NB = DW / 8;
  localparam int AW = RF_AW;

  logic [NB-1:0] w_we_m, w_we_s;
  logic [AW-1:0] w_waddr_m, w_waddr_s;
  logic [DW-1:0] w_wdata_m, w_wdata_s;

  assign w_we_m    = ws_to_rf_bus_main[RF_WE_MSB:RF_WE_LSB];
  assign w_waddr_m = ws_to_rf_bus_main[RF_WADDR_MSB:RF_WADDR_LSB];
  assign w_wdata_m = ws_to_rf_bus_main[RF_WDATA_MSB:RF_WDATA_LSB];
  assign w_we_s    = ws_to_rf_bus_sub[RF_WE_MSB:RF_WE_LSB];
  assign w_waddr_s = ws_to_rf_bus_sub[RF_WADDR_MSB:RF_WADDR_LSB];
  assign w_wdata_s = ws_to_rf_bus_sub[RF_WDATA_MSB:RF_WDATA_LSB];

  logic [DW-1:0] r_rf [NREG];
  logic [NB-1:0] w_be [NREG];
  logic [DW-1:0] w_bd [NREG];
  logic          r_conflict;
  logic          w_conflict;

  // Register 0 has no merge instance, so it can never be written.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_wr
    if (gi == 0) begin : g_zero
      assign w_be[gi] = '0;
      assign w_bd[gi] = '0;
    end else begin : g_merge
      rf_byte_merge #(.NB(NB), .AW(AW), .DW(DW)) u_merge (
        .we_main     (w_we_m),
        .waddr_main  (w_waddr_m),
        .wdata_main  (w_wdata_m),
        .we_sub      (w_we_s),
        .waddr_sub   (w_waddr_s),
        .wdata_sub   (w_wdata_s),
        .ws_first_sub(ws_first_sub),
        .tgt         (AW'(gi)),
        .be          (w_be[gi]),
        .bdata       (w_bd[gi])
      );
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++)
        for (int b = 0; b < NB; b++)
          if (w_be[i][b]) r_rf[i][b*8 +: 8] <= w_bd[i][b*8 +: 8];
    end
  end

  assign w_conflict = (w_waddr_m == w_waddr_s) && (w_waddr_m != '0) && |(w_we_m & w_we_s);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_conflict <= 1'b0;
    else         r_conflict <= w_conflict;
  end

  assign wr_conflict = r_conflict;

  logic [AW-1:0] w_raddr [4];
  logic [DW-1:0] w_rdata [4];

  assign w_raddr[0] = raddr0;
  assign w_raddr[1] = raddr1;
  assign w_raddr[2] = raddr2;
  assign w_raddr[3] = raddr3;

  for (genvar gp = 0; gp < 4; gp++) begin : g_rd
`ifdef RF_BYPASS_EN
    logic [NB-1:0] w_fbe;
    logic [DW-1:0] w_fbd;
    logic [DW-1:0] w_rd;

    rf_byte_merge #(.NB(NB), .AW(AW), .DW(DW)) u_fwd (
      .we_main     (w_we_m),
      .waddr_main  (w_waddr_m),
      .wdata_main  (w_wdata_m),
      .we_sub      (w_we_s),
      .waddr_sub   (w_waddr_s),
      .wdata_sub   (w_wdata_s),
      .ws_first_sub(ws_first_sub),
      .tgt         (w_raddr[gp]),
      .be          (w_fbe),
      .bdata       (w_fbd)
    );

    always_comb begin
      w_rd = r_rf[w_raddr[gp]];
      for (int b = 0; b < NB; b++)
        if (w_fbe[b]) w_rd[b*8 +: 8] = w_fbd[b*8 +: 8];
      if (w_raddr[gp] == '0) w_rd = '0;
    end

    assign w_rdata[gp] = w_rd;
`else
    assign w_rdata[gp] = (w_raddr[gp] == '0) ? '0 : r_rf[w_raddr[gp]];
`endif
  end

  assign rdata0 = w_rdata[0];
  assign rdata1 = w_rdata[1];
  assign rdata2 = w_rdata[2];
  assign rdata3 = w_rdata[3];

endmodule
